// File: rtl/hex_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : hex_scan_controller
// Function : Time-multiplexed 4-digit hex display scanner with a one-deep
//            load buffer committed only at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module hex_scan_controller #(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_WIDTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        loadValid,
    input  logic [15:0] inputBus,
    input  logic        blankEn,
    output logic        loadReady,
    output logic [3:0]  hexOut,
    output logic        blankOut,
    output logic [3:0]  digitSel,
    output logic        frameDone
);

    localparam logic [DIV_WIDTH-1:0] c_DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } loadState_t;

    loadState_t           r_state;
    loadState_t           w_stateNext;
    logic [DIV_WIDTH-1:0] r_prescaler;
    logic [1:0]           r_index;
    logic [15:0]          r_active;
    logic [15:0]          r_pending;

    logic                 w_tick;
    logic                 w_frameWrap;
    logic                 w_accept;
    logic                 w_commit;
    logic [1:0]           w_nextIndex;
    logic [15:0]          w_nextActive;
    logic [3:0]           w_nibble;
    logic                 w_blankDigit;

    assign w_tick       = (r_prescaler == c_DIV_LAST);
    assign w_frameWrap  = w_tick && (r_index == 2'd3);
    assign loadReady    = (r_state == ST_EMPTY) && !reset;
    assign w_accept     = loadValid && loadReady;
    assign w_commit     = w_frameWrap && (r_state == ST_PENDING);
    assign w_nextIndex  = r_index + 2'd1;
    // Digit 0 of a new frame must already show the freshly committed value.
    assign w_nextActive = w_commit ? r_pending : r_active;
    assign w_nibble     = w_nextActive[{w_nextIndex, 2'b00} +: 4];

    always_comb begin
        w_blankDigit = 1'b0;
        case (w_nextIndex)
            2'd3:    w_blankDigit = (w_nextActive[15:12] == 4'h0);
            2'd2:    w_blankDigit = (w_nextActive[15:8]  == 8'h00);
            2'd1:    w_blankDigit = (w_nextActive[15:4]  == 12'h000);
            default: w_blankDigit = 1'b0;
        endcase
        w_blankDigit = w_blankDigit && blankEn;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_EMPTY:   if (w_accept) w_stateNext = ST_PENDING;
            ST_PENDING: if (w_commit) w_stateNext = ST_EMPTY;
            default:    w_stateNext = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prescaler <= '0;
            r_index     <= 2'd0;
            r_active    <= 16'h0000;
            r_pending   <= 16'h0000;
            digitSel    <= 4'b1110;
            hexOut      <= 4'h0;
            blankOut    <= 1'b0;
            frameDone   <= 1'b0;
        end else begin
            r_prescaler <= w_tick ? '0 : r_prescaler + DIV_WIDTH'(1);
            frameDone   <= w_frameWrap;
            if (w_tick) begin
                r_index  <= w_nextIndex;
                digitSel <= w_blankDigit ? 4'b1111 : ~(4'b0001 << w_nextIndex);
                hexOut   <= w_blankDigit ? 4'h0 : w_nibble;
                blankOut <= w_blankDigit;
            end
            if (w_commit) begin
                r_active <= r_pending;
            end
            if (w_accept) begin
                r_pending <= inputBus;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_scan_controller
// Function : Scoreboard bench for hex_scan_controller with REFRESH_DIV = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_scan_controller;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clock = 1'b0;
    logic        reset;
    logic        loadValid;
    logic [15:0] inputBus;
    logic        blankEn;
    logic        loadReady;
    logic [3:0]  hexOut;
    logic        blankOut;
    logic [3:0]  digitSel;
    logic        frameDone;

    hex_scan_controller #(.REFRESH_DIV(DIV), .DIV_WIDTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .loadValid (loadValid),
        .inputBus  (inputBus),
        .blankEn   (blankEn),
        .loadReady (loadReady),
        .hexOut    (hexOut),
        .blankOut  (blankOut),
        .digitSel  (digitSel),
        .frameDone (frameDone)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] hex;
        logic       blank;
        logic       fd;
        logic       ready;
    } exp_t;

    exp_t        expQ[$];
    int          nCompared   = 0;
    int          nMismatched = 0;

    // Reference model: frame position counted in cycles since reset release.
    int          mCnt;
    logic [15:0] mActive;
    logic [15:0] mPending;
    bit          mPend;
    exp_t        mOut;

    task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelEdge();
        bit          wrap;
        bit          acc;
        int          d;
        logic [15:0] v;
        if (reset) begin
            mCnt     = 0;
            mActive  = 16'h0;
            mPending = 16'h0;
            mPend    = 1'b0;
            mOut     = '{sel: 4'b1110, hex: 4'h0, blank: 1'b0, fd: 1'b0, ready: 1'b0};
        end else begin
            wrap = (mCnt == FRAME - 1);
            acc  = loadValid && !mPend;
            if (wrap && mPend) begin
                mActive = mPending;
                mPend   = 1'b0;
            end
            if (acc) begin
                mPending = inputBus;
                mPend    = 1'b1;
            end
            mCnt    = (mCnt + 1) % FRAME;
            mOut.fd = wrap;
            if (mCnt % DIV == 0) begin
                d = mCnt / DIV;
                v = mActive >> (4 * d);
                if (blankEn && d != 0 && v == 16'h0) begin
                    mOut.sel   = 4'b1111;
                    mOut.hex   = 4'h0;
                    mOut.blank = 1'b1;
                end else begin
                    mOut.sel   = 4'hF ^ (4'h1 << d);
                    mOut.hex   = v[3:0];
                    mOut.blank = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            modelEdge();
            mOut.ready = !reset && !mPend;
            expQ.push_back(mOut);
            #1;
            e = expQ.pop_front();
            checkValue("digitSel",  16'(digitSel),  16'(e.sel));
            checkValue("hexOut",    16'(hexOut),    16'(e.hex));
            checkValue("blankOut",  16'(blankOut),  16'(e.blank));
            checkValue("frameDone", 16'(frameDone), 16'(e.fd));
            checkValue("loadReady", 16'(loadReady), 16'(e.ready));
        end
    endtask

    task automatic loadValue(input logic [15:0] v);
        loadValid = 1'b1;
        inputBus  = v;
        step(1);
        loadValid = 1'b0;
        checkValue("ready_drop", 16'(loadReady), 16'h0);
    endtask

    task automatic waitWrapCycle();
        int guard;
        guard = 0;
        while (mCnt != FRAME - 1 && guard < 4 * FRAME) begin
            step(1);
            guard++;
        end
        checkValue("wrap_wait", 16'(mCnt), 16'(FRAME - 1));
    endtask

    initial begin
        reset     = 1'b1;
        loadValid = 1'b0;
        inputBus  = 16'h0;
        blankEn   = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
        checkValue("ready_after_reset", 16'(loadReady), 16'h1);
        step(2 * FRAME);

        loadValue(16'h1A2F);
        step(3 * FRAME);

        blankEn = 1'b1;
        loadValue(16'h00B0);
        step(3 * FRAME);
        blankEn = 1'b0;
        step(FRAME + 3);
        blankEn = 1'b1;

        loadValue(16'h0000);
        step(3 * FRAME);

        blankEn = 1'b0;
        waitWrapCycle();
        loadValid = 1'b1;
        inputBus  = 16'h1111;
        step(1);
        inputBus  = 16'h2222;
        step(2);
        loadValid = 1'b0;
        step(3 * FRAME);

        loadValue(16'hBEEF);
        step(5);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        checkValue("ready_after_midreset", 16'(loadReady), 16'h1);
        step(3 * FRAME);

        checkValue("queue_empty", 16'(expQ.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
